// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around the bit centre.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [EW-1:0] CNT_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] CNT_MID  = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] CNT_DEC  = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] data;
  logic                  rx_m, rx_s;
  logic                  par_en, par_type, par_err;
  logic                  s_mid, bit_val;
  logic                  decide, wrap;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_IN;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] CNT_PRE = EW'(OVERSAMPLE / 2 - 1);
  logic s_pre;

  // Third vote is the live rx_s on the decision cycle itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_pre <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (edge_cnt == CNT_PRE) s_pre <= rx_s;
      if (edge_cnt == CNT_MID) s_mid <= rx_s;
    end
  end

  assign bit_val = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s_mid <= 1'b0;
    else if (edge_cnt == CNT_MID) s_mid <= rx_s;
  end

  assign bit_val = s_mid;
`endif

  assign decide = (edge_cnt == CNT_DEC);
  assign wrap   = (edge_cnt == CNT_LAST);
  assign Busy   = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      data         <= '0;
      par_en       <= 1'b0;
      par_type     <= 1'b0;
      par_err      <= 1'b0;
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;

      if (state == IDLE) edge_cnt <= '0;
      else               edge_cnt <= wrap ? '0 : edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
            par_en   <= Parity_Enable;
            par_type <= Parity_Type;
          end
        end
        START: begin
          if (decide && bit_val) state <= IDLE;
          else if (wrap)         state <= DATA;
        end
        DATA: begin
          if (decide) data[bit_cnt] <= bit_val;
          if (wrap) begin
            if (bit_cnt == BIT_LAST) state <= par_en ? PARITY : STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (decide) par_err <= bit_val ^ (^data) ^ par_type;
          if (wrap)   state   <= STOP;
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is seen without delay.
          if (decide) begin
            state        <= IDLE;
            Stop_Error   <= ~bit_val;
            Parity_Error <= par_err;
            if (bit_val && !par_err) begin
              P_Data     <= data;
              Data_Valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter; same frame format.
- Frame: start 0, DATA_WIDTH data bits LSB first, optional parity, one stop 1.
- Oversamples `RX_IN` at OVERSAMPLE clocks per bit; reports each frame on `P_Data` with a one-cycle `Data_Valid`, or flags a parity or stop error.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, clocks per bit; even, ≥4.
- CLK  in  1  sampling clock; one bit period = OVERSAMPLE cycles.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line; idle high; asynchronous to CLK.
- Parity_Enable  in  1  1 = parity bit present.
- Parity_Type  in  1  0 = even, 1 = odd.
- P_Data  out  DATA_WIDTH  last received data word.
- Data_Valid  out  1  one-cycle pulse; good frame on `P_Data`.
- Parity_Error  out  1  one-cycle pulse; parity mismatch.
- Stop_Error  out  1  one-cycle pulse; stop bit sampled 0.
- Busy  out  1  high while not in IDLE.

## Operation
- `RX_IN` passes a 2-flop synchronizer; all logic uses the synced value `rx_s`.
- `Parity_Enable` and `Parity_Type` are latched on IDLE→START; mid-frame changes are ignored.
- FSM states:
  - IDLE: `rx_s` = 0 → START.
  - START: sampled start bit = 1 → IDLE, no outputs (glitch reject); else → DATA.
  - DATA: shift sampled bit into bit `bit_cnt` (LSB first); after bit DATA_WIDTH-1 → PARITY if enabled, else STOP.
  - PARITY: compare against XOR of data (even), or its inverse (odd).
  - STOP: evaluate outputs → IDLE.
- Counters:
  - `edge_cnt` runs 0..OVERSAMPLE-1 per bit and is 0 on the first START cycle.
  - Bit boundaries fall where `edge_cnt` wraps.
  - `bit_cnt` is $clog2(DATA_WIDTH) wide.
- A bit's value is decided at `edge_cnt` == OVERSAMPLE/2+1.
- Stop decision cycle:
  - Stop = 1 and no parity error → `P_Data` updated, `Data_Valid` pulses.
  - Stop = 0 → `Stop_Error` pulses.
  - Parity mismatch → `Parity_Error` pulses.
  - Both errors may pulse together.
  - `P_Data` is unchanged on any error.
- FSM returns to IDLE mid-stop-bit, so a start edge of the next frame is caught immediately (back-to-back frames).
- Reset: state IDLE, counters 0, synchronizer flops 1, all outputs 0. Reset mid-frame discards the partial frame; no pulses.

## Timing
- Detection delay: `RX_IN` falling edge → 2 cycles through the synchronizer → START entered.
- Bit k decision (start = 0): START entry + k·OVERSAMPLE + OVERSAMPLE/2+1.
- Outputs are registered and asserted the cycle after the stop decision.
  - Pulses last exactly 1 cycle.
  - `Busy` falls in that same cycle.
- Frame latency, `RX_IN` start edge → `Data_Valid`: 2 + (F-1)·OVERSAMPLE + OVERSAMPLE/2+2 cycles, where F = DATA_WIDTH+2+Parity_Enable.
- `Busy` rises the cycle START is entered.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Bit value = 2-of-3 majority of `rx_s` at `edge_cnt` OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Isolated single-cycle glitches are rejected.
- Undefined:
  - Bit value = single `rx_s` sample at `edge_cnt` OVERSAMPLE/2, held to the decision cycle.
  - Decision timing and all latencies are identical in both modes.

## Test plan
All cases use OVERSAMPLE=8, DATA_WIDTH=8.
- Frame 0xA5, parity off, stop 1 → `P_Data`=0xA5, `Data_Valid` 1 cycle, 2+9·8+6 = 80 cycles after start edge; no errors.
- 0xA5 with even parity bit 0, then odd parity bit 1 (config latched accordingly) → both valid.
- 0xA5 sent with even parity bit 1 → `Parity_Error` pulse; no `Data_Valid`; `P_Data` keeps its prior value.
- 0x3C with stop bit 0 → `Stop_Error` pulse; no `Data_Valid`.
- Glitches:
  - `RX_IN` low for 2 cycles in idle → FSM returns to IDLE; no pulses; `Busy` high for ≤1 bit.
  - With UART_RX_MAJORITY_EN, a 1-cycle high glitch at a data bit center in 0x00 → `P_Data`=0x00.
- Back-to-back frames 0x01, 0xFE with no idle gap → two `Data_Valid` pulses 80 cycles apart. Then `RST` asserted mid-third frame → all outputs 0, no pulse; next clean frame 0x55 received correctly.
